// File: rtl/awgn_ctrl_pkg.sv
// Shared types and helpers for the AWGN stream controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package awgn_ctrl_pkg;

    localparam int SEED_W       = 192;  // six 32-bit Tausworthe seeds {s1..s6}
    localparam int PIPE_LAT_DEF = 8;    // datapath warm-up, enabled cycles
    localparam int SAT_W        = 48;   // working width for the saturation helper

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARM,
        RUN,
        DONE
    } state_t;

    // Clamp a signed value to the range of a w-bit two's complement number.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/awgn_sat_scale.sv
// Scales one signed sample by an unsigned Q4.4 gain and saturates to SMP_W.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input. Only built when AWGN_SAT_SCALE_EN is defined.
`ifdef AWGN_SAT_SCALE_EN
module awgn_sat_scale
    import awgn_ctrl_pkg::*;
#(
    parameter int SMP_W = 16
) (
    input  logic [SMP_W-1:0] x,
    input  logic [7:0]       gain,
    output logic [SMP_W-1:0] y
);

    localparam int PW = SMP_W + 9;

    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    shifted;
    logic signed [SAT_W-1:0] wide;

    // Signed multiply by zero-extended gain, drop the 4 fraction bits, clamp.
    always_comb begin
        prod    = PW'($signed(x)) * PW'($signed({1'b0, gain}));
        shifted = prod >>> 4;
        wide    = sat_signed(SAT_W'(shifted), SMP_W);
        y       = wide[SMP_W-1:0];
    end

endmodule
`endif

// File: rtl/awgn_stream_ctrl.sv
// Seeds and warms the Box-Muller datapath, then serialises x0/x1 pairs onto one valid/ready stream.
// Latency: 1 LOAD + PIPE_LAT WARM cycles to first sample, then 1 sample/cycle with m_ready high.
// Backpressure: gen_en is withheld while the pair buffer is occupied, so no pair is dropped; stalls hold m_data.
// Optional gain port and saturating scaler are enabled by the AWGN_SAT_SCALE_EN macro.
module awgn_stream_ctrl
    import awgn_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int CNT_W    = 16,
    parameter int SMP_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
`ifdef AWGN_SAT_SCALE_EN
    input  logic [7:0]        gain,
`endif
    input  logic              start,
    input  logic [CNT_W-1:0]  num_samples,
    input  logic [SEED_W-1:0] seed_in,
    output logic [SEED_W-1:0] gen_seed,
    output logic              gen_load,
    output logic              gen_en,
    input  logic [SMP_W-1:0]  gen_x0,
    input  logic [SMP_W-1:0]  gen_x1,
    output logic [SMP_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam int WARM_W = $clog2(PIPE_LAT + 1);

    state_t             state;
    logic [SEED_W-1:0]  seed_q;
    logic [CNT_W-1:0]   samples_left;
    logic [CNT_W-1:0]   pairs_left;
    logic [WARM_W-1:0]  warm_cnt;
    logic [SMP_W-1:0]   pb_x0;
    logic [SMP_W-1:0]   pb_x1;
    logic               pb_vld;
    logic               sel;
    logic [SMP_W-1:0]   cap_x0;
    logic [SMP_W-1:0]   cap_x1;
    logic               fire;

`ifdef AWGN_SAT_SCALE_EN
    awgn_sat_scale #(.SMP_W(SMP_W)) u_scale_x0 (
        .x    (gen_x0),
        .gain (gain),
        .y    (cap_x0)
    );

    awgn_sat_scale #(.SMP_W(SMP_W)) u_scale_x1 (
        .x    (gen_x1),
        .gain (gain),
        .y    (cap_x1)
    );
`else
    assign cap_x0 = gen_x0;
    assign cap_x1 = gen_x1;
`endif

    assign fire     = pb_vld & m_ready;
    assign m_valid  = pb_vld;
    assign m_data   = sel ? pb_x1 : pb_x0;
    assign gen_seed = seed_q;
    assign gen_load = (state == LOAD);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Advance the datapath during warm-up, and in RUN only when the pair buffer
    // is empty or its last sample leaves this cycle, so a new pair always has a home.
    always_comb begin
        gen_en = 1'b0;
        case (state)
            WARM:    gen_en = 1'b1;
            RUN:     gen_en = (pairs_left != '0) & (!pb_vld | (fire & sel));
            default: gen_en = 1'b0;
        endcase
    end

    // Run sequencing, pair buffer and sample/pair accounting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            seed_q       <= '0;
            samples_left <= '0;
            pairs_left   <= '0;
            warm_cnt     <= '0;
            pb_x0        <= '0;
            pb_x1        <= '0;
            pb_vld       <= 1'b0;
            sel          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (num_samples != '0)) begin
                        seed_q       <= seed_in;
                        samples_left <= num_samples;
                        // ceil(n/2) without a wider adder: n>>1 plus the odd bit never wraps.
                        pairs_left   <= (num_samples >> 1) + CNT_W'(num_samples[0]);
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    warm_cnt <= '0;
                    state    <= WARM;
                end
                WARM: begin
                    warm_cnt <= warm_cnt + WARM_W'(1);
                    if (warm_cnt == WARM_W'(PIPE_LAT - 1)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (gen_en) begin
                        pb_x0      <= cap_x0;
                        pb_x1      <= cap_x1;
                        pb_vld     <= 1'b1;
                        sel        <= 1'b0;
                        pairs_left <= pairs_left - CNT_W'(1);
                    end else if (fire) begin
                        if (!sel) begin
                            sel <= 1'b1;
                        end else begin
                            pb_vld <= 1'b0;
                        end
                    end
                    if (fire) begin
                        samples_left <= samples_left - CNT_W'(1);
                        // Last sample: an odd count leaves x1 unsent; drop it here.
                        if (samples_left == CNT_W'(1)) begin
                            pb_vld <= 1'b0;
                            sel    <= 1'b0;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
